serdes_pack: RTL and testbench

//  Lane packer directly downstream of the serdes write driver. Each input beat carries 0..IN_COUNT

---
 rtl/serdes_pack_pkg.sv | 18 +
 rtl/serdes_pack_lane_shift.sv | 33 +++
 rtl/serdes_pack.sv | 109 ++++++++++
 tb/tb_serdes_pack.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serdes_pack_pkg.sv
// Shared types and helpers for the serdes lane packer.
package serdes_pack_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Bits needed to hold values 0..v-1; elaboration-time only.
  function automatic int c_log_2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serdes_pack_lane_shift.sv
// Combinational next-buffer: drop pop_n oldest lanes, append push_n input lanes at wr_off.
// Relies on the buffer invariant that lanes >= fill are zero, so shift-down and insert can be ORed.
module serdes_lane_shift
  import serdes_pack_pkg::*;
#(
  parameter int IN_COUNT  = 10,
  parameter int BUF_LANES = 20,
  parameter int OP_WIDTH  = 16,
  parameter int IDX_W     = 5
) (
  input  logic [BUF_LANES-1:0][OP_WIDTH-1:0] lane_buf,
  input  logic [IDX_W-1:0]                   pop_n,
  input  logic [IDX_W-1:0]                   wr_off,
  input  logic [IDX_W-1:0]                   push_n,
  input  logic [IN_COUNT-1:0][OP_WIDTH-1:0]  lanes,
  output logic [BUF_LANES-1:0][OP_WIDTH-1:0] buf_nxt
);

  logic [BUF_LANES-1:0][OP_WIDTH-1:0] ins;

  // Mask input lanes beyond push_n and zero-extend to buffer depth.
  for (genvar i = 0; i < BUF_LANES; i++) begin : g_mask
    if (i < IN_COUNT) begin : g_in
      assign ins[i] = (IDX_W'(i) < push_n) ? lanes[i] : '0;
    end else begin : g_pad
      assign ins[i] = '0;
    end
  end

  assign buf_nxt = (lane_buf >> (32'(pop_n) * 32'(OP_WIDTH)))
                 | (ins << (32'(wr_off) * 32'(OP_WIDTH)));

endmodule

// File: rtl/serdes_pack.sv
// Lane packer: densely packs 0..IN_COUNT ops per beat into OUT_COUNT-lane words;
// a flush pulse drains the residue as one zero-padded word.
// Optional SERDES_PACK_STATS_EN adds words_out / partial_out counters.
module serdes_pack
  import serdes_pack_pkg::*;
#(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 10,
  parameter int OP_WIDTH  = 16,
  parameter int IN_WIDTH  = IN_COUNT * OP_WIDTH,
  parameter int OUT_WIDTH = OUT_COUNT * OP_WIDTH,
  parameter int COUNT_W   = c_log_2(IN_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [COUNT_W-1:0]   count,
  input  logic                 s_write_req,
  input  logic                 s_write_flush,
  output logic                 s_write_ready,
  input  logic [IN_WIDTH-1:0]  s_write_data,
  output logic                 m_write_req,
  input  logic                 m_write_ready,
  output logic [OUT_WIDTH-1:0] m_write_data
`ifdef SERDES_PACK_STATS_EN
  ,
  output logic [31:0]          words_out,
  output logic [31:0]          partial_out
`endif
);

  localparam int BUF_LANES = IN_COUNT + OUT_COUNT;
  localparam int FILL_W    = c_log_2(BUF_LANES + 1);

  state_t                             state, state_nxt;
  logic [FILL_W-1:0]                  fill, fill_nxt, pop_n, push_n, wr_off;
  logic [BUF_LANES-1:0][OP_WIDTH-1:0] lane_buf, buf_nxt;
  logic [IN_COUNT-1:0][OP_WIDTH-1:0]  lanes;
  logic                               pop, push;

  assign lanes         = s_write_data;
  assign s_write_ready = (state == ACCUM) && (int'(fill) + IN_COUNT <= BUF_LANES);
  assign m_write_req   = (int'(fill) >= OUT_COUNT) || (state == FLUSH && fill != '0);
  assign m_write_data  = lane_buf[OUT_COUNT-1:0];
  assign pop           = m_write_req && m_write_ready;
  assign push          = s_write_req && s_write_ready;

  // Lane counts moved this cycle; count is clamped to IN_COUNT.
  always_comb begin
    pop_n  = '0;
    push_n = '0;
    if (pop)
      pop_n = (int'(fill) < OUT_COUNT) ? fill : FILL_W'(OUT_COUNT);
    if (push)
      push_n = (int'(count) > IN_COUNT) ? FILL_W'(IN_COUNT) : FILL_W'(count);
    wr_off   = fill - pop_n;
    fill_nxt = wr_off + push_n;
  end

  serdes_lane_shift #(
    .IN_COUNT (IN_COUNT),
    .BUF_LANES(BUF_LANES),
    .OP_WIDTH (OP_WIDTH),
    .IDX_W    (FILL_W)
  ) u_shift (
    .lane_buf(lane_buf),
    .pop_n   (pop_n),
    .wr_off  (wr_off),
    .push_n  (push_n),
    .lanes   (lanes),
    .buf_nxt (buf_nxt)
  );

  // Next state: flush enters FLUSH (ignored there); leave once the buffer empties.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (s_write_flush) state_nxt = FLUSH;
      FLUSH:   if (fill_nxt == '0) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State, fill and buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ACCUM;
      fill     <= '0;
      lane_buf <= '0;
    end else begin
      state    <= state_nxt;
      fill     <= fill_nxt;
      lane_buf <= buf_nxt;
    end
  end

`ifdef SERDES_PACK_STATS_EN
  // Count accepted words, and those that were zero-padded partials.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      words_out   <= '0;
      partial_out <= '0;
    end else if (pop) begin
      words_out <= words_out + 32'd1;
      if (int'(fill) < OUT_COUNT) partial_out <= partial_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_pack.sv
// Directed bench for serdes_pack with IN_COUNT=4, OUT_COUNT=3, OP_WIDTH=16.
module tb_serdes_pack;

  localparam int IN_COUNT  = 4;
  localparam int OUT_COUNT = 3;
  localparam int OP_WIDTH  = 16;
  localparam int COUNT_W   = 3;

  logic                            clk = 1'b0;
  logic                            resetn = 1'b0;
  logic [COUNT_W-1:0]              count = '0;
  logic                            s_write_req = 1'b0;
  logic                            s_write_flush = 1'b0;
  logic                            s_write_ready;
  logic [IN_COUNT*OP_WIDTH-1:0]    s_write_data = '0;
  logic                            m_write_req;
  logic                            m_write_ready = 1'b1;
  logic [OUT_COUNT*OP_WIDTH-1:0]   m_write_data;
`ifdef SERDES_PACK_STATS_EN
  logic [31:0]                     words_out, partial_out;
`endif

  int tests = 0;
  int fails = 0;

  serdes_pack #(
    .IN_COUNT (IN_COUNT),
    .OUT_COUNT(OUT_COUNT),
    .OP_WIDTH (OP_WIDTH),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .count        (count),
    .s_write_req  (s_write_req),
    .s_write_flush(s_write_flush),
    .s_write_ready(s_write_ready),
    .s_write_data (s_write_data),
    .m_write_req  (m_write_req),
    .m_write_ready(m_write_ready),
    .m_write_data (m_write_data)
`ifdef SERDES_PACK_STATS_EN
    ,
    .words_out    (words_out),
    .partial_out  (partial_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] word(input logic [15:0] a, b, c);
    return {16'h0, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check both handshake outputs and the data word in one go.
  task automatic chk_out(input string tag, input logic rdy, input logic req, input logic [63:0] dat);
    chk({tag, ".s_ready"}, {63'h0, s_write_ready}, {63'h0, rdy});
    chk({tag, ".m_req"},   {63'h0, m_write_req},   {63'h0, req});
    chk({tag, ".m_data"},  {16'h0, m_write_data},  dat);
  endtask

  initial begin
    // Reset
    tick(); tick();
    resetn = 1'b1;
    chk_out("reset", 1'b1, 1'b0, 64'h0);

    // 1: three full beats -> four words
    s_write_req = 1'b1; count = 3'd4; s_write_data = beat(1, 2, 3, 4);
    tick(); chk_out("t1.e1", 1'b0, 1'b1, word(1, 2, 3));
    s_write_data = beat(5, 6, 7, 8);
    tick(); chk_out("t1.e2", 1'b1, 1'b0, word(4, 0, 0));
    tick(); chk_out("t1.e3", 1'b0, 1'b1, word(4, 5, 6));
    s_write_data = beat(9, 10, 11, 12);
    tick(); chk_out("t1.e4", 1'b1, 1'b0, word(7, 8, 0));
    tick(); chk_out("t1.e5", 1'b0, 1'b1, word(7, 8, 9));
    s_write_req = 1'b0;
    tick(); chk_out("t1.e6", 1'b1, 1'b1, word(10, 11, 12));
    tick(); chk_out("t1.e7", 1'b1, 1'b0, 64'h0);

    // 2: count=2 (upper lanes junk), count=0, flush -> {1,2,0}
    s_write_req = 1'b1; count = 3'd2; s_write_data = beat(1, 2, 16'hAAAA, 16'hBBBB);
    tick(); chk_out("t2.c2", 1'b1, 1'b0, word(1, 2, 0));
    count = 3'd0; s_write_data = beat(16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF);
    tick(); chk_out("t2.c0", 1'b1, 1'b0, word(1, 2, 0));
    s_write_req = 1'b0; s_write_flush = 1'b1;
    tick(); chk_out("t2.flush", 1'b0, 1'b1, word(1, 2, 0));
    s_write_flush = 1'b0;
    tick(); chk_out("t2.done", 1'b1, 1'b0, 64'h0);

    // 3: consumer stalled, back-to-back beats
    m_write_ready = 1'b0;
    s_write_req = 1'b1; count = 3'd4; s_write_data = beat(1, 2, 3, 4);
    tick(); chk_out("t3.b1", 1'b0, 1'b1, word(1, 2, 3));
    s_write_data = beat(5, 6, 7, 8);
    tick(); chk_out("t3.hold1", 1'b0, 1'b1, word(1, 2, 3));
    tick(); chk_out("t3.hold2", 1'b0, 1'b1, word(1, 2, 3));
    m_write_ready = 1'b1;
    tick(); chk_out("t3.pop", 1'b1, 1'b0, word(4, 0, 0));
    tick(); chk_out("t3.b2", 1'b0, 1'b1, word(4, 5, 6));
    s_write_req = 1'b0;
    tick(); chk_out("t3.rem", 1'b1, 1'b0, word(7, 8, 0));
    s_write_flush = 1'b1;
    tick(); chk_out("t3.flush", 1'b0, 1'b1, word(7, 8, 0));
    s_write_flush = 1'b0;
    tick(); chk_out("t3.done", 1'b1, 1'b0, 64'h0);

    // 4: flush while empty
    s_write_flush = 1'b1;
    tick(); chk_out("t4.flush", 1'b0, 1'b0, 64'h0);
    s_write_flush = 1'b0;
    tick(); chk_out("t4.back", 1'b1, 1'b0, 64'h0);

    // 5: count clamp, then flush coincident with a count=1 beat
    s_write_req = 1'b1; count = 3'd7; s_write_data = beat(1, 2, 3, 4);
    tick(); chk_out("t5.clamp", 1'b0, 1'b1, word(1, 2, 3));
    s_write_req = 1'b0;
    tick(); chk_out("t5.pop", 1'b1, 1'b0, word(4, 0, 0));
    s_write_req = 1'b1; count = 3'd1; s_write_flush = 1'b1;
    s_write_data = beat(9, 16'h1111, 16'h2222, 16'h3333);
    tick(); chk_out("t5.flush", 1'b0, 1'b1, word(4, 9, 0));
    s_write_req = 1'b0; s_write_flush = 1'b0;
    tick(); chk_out("t5.done", 1'b1, 1'b0, 64'h0);
`ifdef SERDES_PACK_STATS_EN
    chk("stats.words", {32'h0, words_out}, 64'd10);
    chk("stats.partial", {32'h0, partial_out}, 64'd3);
`endif

    // 6: asynchronous reset mid-transfer
    m_write_ready = 1'b0;
    s_write_req = 1'b1; count = 3'd4; s_write_data = beat(1, 2, 3, 4);
    tick(); chk_out("t6.load", 1'b0, 1'b1, word(1, 2, 3));
    s_write_req = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_out("t6.rst", 1'b1, 1'b0, 64'h0);
`ifdef SERDES_PACK_STATS_EN
    chk("t6.words", {32'h0, words_out}, 64'd0);
    chk("t6.partial", {32'h0, partial_out}, 64'd0);
`endif
    tick();
    resetn = 1'b1; m_write_ready = 1'b1;
    tick(); chk_out("t6.after", 1'b1, 1'b0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
